iob_rom_stream: RTL and testbench
=================================

Name: iob_rom_stream

Overview:
- Sequential read engine placed directly upstream of iob_rom_sp: it drives the ROM's r_en/addr pins and consumes r_data.
- A start command with a base address and a word count streams consecutive ROM words out on a valid/ready interface.
- It absorbs the ROM's fixed 1-cycle read latency and downstream backpressure through a 2-entry output buffer, so no word is dropped or duplicated.
- Used for boot-image and constant-table streaming from ROM into downstream consumers.

Parameters:
- DATA_W, 8, ROM word width and stream data width
- ADDR_W, 4, ROM address width; address space 2**ADDR_W words
- LEN_W, ADDR_W+1, width of the word-count input; max transfer 2**LEN_W-1 words

Ports:
- clk_i  in  1  system clock
- arst_i  in  1  asynchronous active-high reset
- start_i  in  1  command strobe; sampled only when busy_o=0
- base_addr_i  in  ADDR_W  first ROM address of the transfer
- len_i  in  LEN_W  number of words to stream
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse when the final word is accepted downstream
- rom_r_en_o  out  1  connects to ROM r_en_i
- rom_addr_o  out  ADDR_W  connects to ROM addr_i
- rom_r_data_i  in  DATA_W  connects to ROM r_data_o; valid the cycle after an issued read
- data_o  out  DATA_W  stream data (buffer head)
- valid_o  out  1  stream data valid
- ready_i  in  1  downstream accept; transfer when valid_o & ready_i
- last_o  out  1  high with valid_o on the final word of the transfer

Behaviour:
- Clock and reset: one clock, clk_i. Reset arst_i is asynchronous and active-high.
- Reset values: busy_o=0, done_o=0, rom_r_en_o=0, rom_addr_o=0, valid_o=0, last_o=0, data_o=0. Internal state: buffer count=0, issued and accepted counters=0, in-flight flag=0, FSM=IDLE.
- Reset asserted mid-transfer aborts it immediately. In-flight ROM data is discarded and buffer contents are lost.
- FSM states: IDLE, READ, DRAIN.
  - IDLE to READ: start_i=1 and len_i!=0. Latch base_addr_i as the next address, len_i as the word count, clear the counters, busy_o=1.
  - IDLE with start_i=1 and len_i=0: no ROM reads. done_o pulses on the next cycle; busy_o stays 0.
  - READ: issue reads; move to DRAIN after the last read is issued.
  - DRAIN to IDLE: on acceptance of the word with last_o=1. done_o=1 for exactly that following cycle; busy_o=0 from the same edge.
  - start_i while busy_o=1 is ignored, with no effect on the current transfer.
- Read issue (READ only): rom_r_en_o=1 in a cycle iff issued<len and (count + inflight - pop) < 2.
  - pop = valid_o & ready_i in that cycle.
  - rom_addr_o carries the current address during an issue cycle.
  - After each issue the address increments modulo 2**ADDR_W; 2**ADDR_W-1 wraps to 0.
  - rom_addr_o is registered and holds its value when not issuing. rom_r_en_o is 0 outside issue cycles.
- Capture: the cycle after an issue, rom_r_data_i is written into the buffer tail at the next edge. Simultaneous pop and push is allowed.
- Latency: start sampled at edge E0 → read issued in cycle E0..E1 → data on rom_r_data_i in E1..E2 → valid_o=1 from E2. First word appears 2 cycles after the start edge.
- Throughput: with ready_i held at 1, one word per cycle after the first; no bubbles.
- Backpressure: with ready_i=0, issuing stops once count+inflight=2. Buffer never overflows. data_o/valid_o/last_o stay stable while valid_o & !ready_i.
- last_o=1 iff valid_o=1 and the head word is word index len-1.
- Counters: issued and accepted are LEN_W bits and never exceed len.

Test Plan:
- Basic stream: ROM rom[i]=i+32, ADDR_W=4. start base=0 len=16, ready_i=1 → data_o 0x20..0x2F on 16 consecutive cycles, first valid_o 2 cycles after start. last_o only with 0x2F; done_o pulses once.
- Wrap-around: base=14 len=4 → data_o 0x2E,0x2F,0x20,0x21. rom_addr_o sequence 14,15,0,1.
- Backpressure: base=0 len=8, ready_i toggling 1,0,0,1,... and random → every word 0x20..0x27 delivered exactly once, in order. rom_r_en_o never fires while count+inflight=2. Outputs stable while stalled.
- Zero length and ignored start: len=0 → no rom_r_en_o, done_o pulse next cycle. During a len=5 transfer, pulse start_i with base=9 → ignored; output stays 0x20..0x24.
- Reset mid-transfer: assert arst_i after 3 words of len=10 → all outputs return to reset values asynchronously. A new start base=3 len=2 then yields 0x23,0x24 with no stale data.

Source files
------------

// File: rtl/iob_rom_stream.sv
// iob_rom_stream
//   Sequential read engine that sits in front of a single-port ROM with a
//   fixed 1-cycle read latency (iob_rom_sp). A start command streams len_i
//   consecutive ROM words, beginning at base_addr_i and wrapping modulo
//   2**ADDR_W, out on a valid/ready interface. A 2-entry output buffer
//   absorbs the read latency and downstream backpressure.
//
// Handshake: a word moves downstream on every rising clk_i edge where
//   valid_o & ready_i. While valid_o=1 and ready_i=0, data_o, valid_o and
//   last_o hold their values. valid_o never depends on ready_i.
//
// Ports:
//   clk_i, arst_i        clock, asynchronous active-high reset
//   start_i              command strobe, sampled only while busy_o=0
//   base_addr_i, len_i   first ROM address and word count of the command
//   busy_o               transfer in progress
//   done_o               one-cycle pulse after the final word is accepted
//                        (or the cycle after a zero-length command)
//   rom_r_en_o           ROM read enable
//   rom_addr_o           ROM address
//   rom_r_data_i         ROM read data, valid the cycle after a read
//   data_o, valid_o,
//   ready_i, last_o      output stream; last_o marks the final word
module iob_rom_stream #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rom_r_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_r_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o
);

    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  accepted_q, accepted_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];
    logic              done_q, done_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic              last_word;
    logic [2:0]        occupancy;

    assign valid_o   = (count_q != 2'd0);
    assign pop       = valid_o & ready_i;
    // A read issued last cycle has its data on rom_r_data_i now.
    assign push      = inflight_q;
    assign last_word = (accepted_q == (len_q - LEN_ONE));
    assign last_o    = valid_o & last_word;

    // Slots committed after this cycle: buffered words plus the word in
    // flight, minus the word leaving now. Counting the pop in the same
    // cycle is what lets ready_i=1 sustain one word per cycle.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == ST_READ) && (issued_q < len_q) && (occupancy < 3'd2);

    assign rom_r_en_o = issue;
    assign rom_addr_o = addr_q;
    assign data_o     = buf_q[rd_ptr_q];
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        inflight_d = issue;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        buf_d      = buf_q;
        done_d     = 1'b0;

        if (issue) begin
            addr_d   = addr_q + ADDR_ONE;
            issued_d = issued_q + LEN_ONE;
        end

        if (push) begin
            buf_d[wr_ptr_q] = rom_r_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d   = ~rd_ptr_q;
            accepted_d = accepted_q + LEN_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d    = ST_READ;
                        addr_d     = base_addr_i;
                        len_d      = len_i;
                        issued_d   = '0;
                        accepted_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (issue && ((issued_q + LEN_ONE) == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && last_word) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_iob_rom_stream.sv
module tb_iob_rom_stream;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = ADDR_W + 1;

  logic              clk_i;
  logic              arst_i;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [LEN_W-1:0]  len_i;
  logic              busy_o;
  logic              done_o;
  logic              rom_r_en_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_r_data_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic              last_o;

  iob_rom_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rom_r_en_o  (rom_r_en_o),
    .rom_addr_o  (rom_addr_o),
    .rom_r_data_i(rom_r_data_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_o      (last_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------- ROM model: rom[i] = i + 32, 1-cycle read ----------------
  logic [DATA_W-1:0] rom_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = DATA_W'(i + 32);
  end
  always @(posedge clk_i) begin
    if (rom_r_en_o) rom_r_data_i <= rom_mem[rom_addr_o];
  end

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_bad = 0;
  logic [DATA_W:0]   exp_q[$];   // {last, data}
  logic [ADDR_W-1:0] addr_log[$];
  int rd_issued = 0;     // reads issued since reset
  int rd_accepted = 0;   // words accepted since reset
  int rd_total = 0;      // reads issued overall
  int acc_words = 0;     // words accepted overall
  int done_cnt = 0;
  logic done_prev = 1'b0;
  logic stall_pend = 1'b0;
  logic [DATA_W-1:0] stall_data;
  logic stall_last;
  int ready_mode = 0;    // 0: always ready, 1: table then random, 2: random
  int ready_idx = 0;
  logic ready_pat [12] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0: ready_i = 1'b1;
        1: begin
          if (ready_idx < 12) ready_i = ready_pat[ready_idx];
          else ready_i = 1'($urandom_range(0, 1));
          ready_idx++;
        end
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [DATA_W:0] e;
    int outstanding;
    forever begin
      @(negedge clk_i);
      if (arst_i) begin
        stall_pend  = 1'b0;
        rd_issued   = 0;
        rd_accepted = 0;
        done_prev   = 1'b0;
      end else begin
        if (stall_pend) begin
          check("stall_valid", 32'(valid_o), 32'd1);
          check("stall_data", 32'(data_o), 32'(stall_data));
          check("stall_last", 32'(last_o), 32'(stall_last));
        end
        stall_pend = valid_o && !ready_i;
        stall_data = data_o;
        stall_last = last_o;

        if (rom_r_en_o) begin
          outstanding = rd_issued - rd_accepted - ((valid_o && ready_i) ? 1 : 0);
          check("issue_room", 32'(outstanding < 2), 32'd1);
          addr_log.push_back(rom_addr_o);
          rd_issued++;
          rd_total++;
        end

        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'(data_o), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("word_data", 32'(data_o), 32'(e[DATA_W-1:0]));
            check("word_last", 32'(last_o), 32'(e[DATA_W]));
          end
          rd_accepted++;
          acc_words++;
        end

        if (done_o) begin
          done_cnt++;
          if (done_prev) check("done_single", 32'd1, 32'd0);
        end
        done_prev = done_o;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issues a command and returns 1 time unit after the edge that samples it.
  task automatic start_cmd(input int base, input int len, input bit expect_words);
    @(posedge clk_i);
    #1;
    start_i     = 1'b1;
    base_addr_i = ADDR_W'(base);
    len_i       = LEN_W'(len);
    if (expect_words) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back({(i == len - 1), DATA_W'(32 + ((base + i) % 16))});
      end
    end
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while ((busy_o || exp_q.size() != 0) && n < budget);
    if (busy_o || exp_q.size() != 0) begin
      check("idle_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk_i);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    int r0;
    int a0;
    int n;
    arst_i      = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    len_i       = '0;
    #2;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_r_en", 32'(rom_r_en_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    #10;
    arst_i = 1'b0;

    // basic stream: latency, throughput, last, done
    ready_mode = 0;
    d0 = done_cnt;
    start_cmd(0, 16, 1'b1);
    @(negedge clk_i);
    check("lat_e0_valid", 32'(valid_o), 32'd0);
    check("lat_e0_busy", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    check("lat_e1_valid", 32'(valid_o), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      check("stream_valid", 32'(valid_o), 32'd1);
    end
    wait_idle(100);
    check("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("basic_busy_end", 32'(busy_o), 32'd0);

    // wrap-around
    addr_log.delete();
    start_cmd(14, 4, 1'b1);
    wait_idle(100);
    check("wrap_addr_cnt", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      check("wrap_addr0", 32'(addr_log[0]), 32'd14);
      check("wrap_addr1", 32'(addr_log[1]), 32'd15);
      check("wrap_addr2", 32'(addr_log[2]), 32'd0);
      check("wrap_addr3", 32'(addr_log[3]), 32'd1);
    end

    // backpressure: fixed pattern then random
    ready_mode = 1;
    ready_idx  = 0;
    start_cmd(0, 8, 1'b1);
    wait_idle(400);
    ready_mode = 2;
    start_cmd(5, 12, 1'b1);
    wait_idle(600);
    ready_mode = 0;

    // zero length
    r0 = rd_total;
    d0 = done_cnt;
    start_cmd(0, 0, 1'b0);
    @(negedge clk_i);
    check("zero_done", 32'(done_o), 32'd1);
    check("zero_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    check("zero_done_off", 32'(done_o), 32'd0);
    check("zero_no_reads", 32'(rd_total - r0), 32'd0);
    check("zero_done_cnt", 32'(done_cnt - d0), 32'd1);

    // start while busy is ignored
    r0 = rd_total;
    start_cmd(0, 5, 1'b1);
    @(posedge clk_i);
    #1;
    start_i     = 1'b1;
    base_addr_i = ADDR_W'(9);
    len_i       = LEN_W'(3);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_idle(100);
    check("ignored_reads", 32'(rd_total - r0), 32'd5);

    // reset mid-transfer
    a0 = acc_words;
    start_cmd(0, 10, 1'b1);
    n = 0;
    while (acc_words - a0 < 3 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("mid_reach3", 32'(acc_words - a0 >= 3), 32'd1);
    @(posedge clk_i);
    #3;
    arst_i = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    check("mid_rst_r_en", 32'(rom_r_en_o), 32'd0);
    check("mid_rst_addr", 32'(rom_addr_o), 32'd0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_last", 32'(last_o), 32'd0);
    check("mid_rst_data", 32'(data_o), 32'd0);
    exp_q.delete();
    @(posedge clk_i);
    @(posedge clk_i);
    #3;
    arst_i = 1'b0;
    start_cmd(3, 2, 1'b1);
    wait_idle(100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
